// File: rtl/alu_64_if.sv
// Operand/result bundle for the EX-stage ALU: operands and op select flow in,
// the registered result and NZVC flags flow out.
interface alu_64_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [5:0]       SHAMT;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    modport master (
        output A, B, SHAMT, cntrl,
        input  result, negative, zero, overflow, carry_out
    );

    modport slave (
        input  A, B, SHAMT, cntrl,
        output result, negative, zero, overflow, carry_out
    );
endinterface

// File: rtl/alu_64.sv
// 64-bit EX-stage ALU: eight operations selected by cntrl, with result and
// NZVC flags registered for one cycle of latency.
module alu_64 #(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     rst,
    alu_64_if.slave  bus
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_LSR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic             w_add_v;
    logic [WIDTH-1:0] w_result;
    logic             w_c;
    logic             w_v;

    logic [WIDTH-1:0] r_result;
    logic             r_negative;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carry_out;

    // ADD and SUB share one adder: SUB feeds ~B with a carry-in of 1.
    assign w_is_sub = (bus.cntrl == OP_SUB);
    assign w_b_op   = w_is_sub ? ~bus.B : bus.B;
    assign w_sum    = {1'b0, bus.A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_add_v  = (bus.A[WIDTH-1] == w_b_op[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.A[WIDTH-1]);

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (bus.cntrl)
            OP_AND:  w_result = bus.A & bus.B;
            OP_OR:   w_result = bus.A | bus.B;
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = w_add_v;
            end
            OP_LSL:  w_result = bus.A << bus.SHAMT;
            OP_LSR:  w_result = bus.A >> bus.SHAMT;
            OP_XOR:  w_result = bus.A ^ bus.B;
            OP_SUB: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = w_add_v;
            end
            OP_PASS: w_result = bus.B;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_negative  <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            r_result    <= w_result;
            r_negative  <= w_result[WIDTH-1];
            r_zero      <= (w_result == '0);
            r_overflow  <= w_v;
            r_carry_out <= w_c;
        end
    end

    assign bus.result    = r_result;
    assign bus.negative  = r_negative;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;
    assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_alu_64.sv
// Directed bench for alu_64: expectations are queued when each operation is
// driven and checked one edge later when the registered outputs appear.
module tb_alu_64;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_64_if #(.WIDTH(64)) bus();

    alu_64 #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        v;
        logic        c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Independent reference: overflow from a sign-extended 65-bit sum,
    // carry for SUB from an unsigned compare.
    function automatic exp_t model(string tag, logic [2:0] op, logic [63:0] a,
                                   logic [63:0] b, logic [5:0] sh);
        exp_t        e;
        logic [64:0] ux;
        logic [64:0] sx;
        e.tag = tag;
        e.v   = 1'b0;
        e.c   = 1'b0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                ux    = {1'b0, a} + {1'b0, b};
                sx    = {a[63], a} + {b[63], b};
                e.res = ux[63:0];
                e.c   = ux[64];
                e.v   = sx[64] != sx[63];
            end
            3'b011: e.res = a << sh;
            3'b100: e.res = a >> sh;
            3'b101: e.res = a ^ b;
            3'b110: begin
                sx    = {a[63], a} - {b[63], b};
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = sx[64] != sx[63];
            end
            default: e.res = b;
        endcase
        e.n = e.res[63];
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    function automatic exp_t mk(string tag, logic [63:0] res, logic n, logic z,
                                logic v, logic c);
        exp_t e;
        e.tag = tag; e.res = res; e.n = n; e.z = z; e.v = v; e.c = c;
        return e;
    endfunction

    task automatic drive(logic r, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                         logic [5:0] sh, exp_t e);
        rst       = r;
        bus.cntrl = op;
        bus.A     = a;
        bus.B     = b;
        bus.SHAMT = sh;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [67:0] obs;
        logic [67:0] req;
        e   = exp_q.pop_front();
        obs = {bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out};
        req = {e.res, e.n, e.z, e.v, e.c};
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed res=%h nzvc=%b%b%b%b expected res=%h nzvc=%b%b%b%b",
                   e.tag, bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out,
                   e.res, e.n, e.z, e.v, e.c);
        end
        $display("step %-12s res=%h nzvc=%b%b%b%b", e.tag, bus.result, bus.negative,
                 bus.zero, bus.overflow, bus.carry_out);
    endtask

    task automatic step(logic r, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                        logic [5:0] sh, exp_t e);
        drive(r, op, a, b, sh, e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [5:0]  rs;
        logic [2:0]  rop;

        // Reset with arbitrary inputs
        step(1'b1, 3'b010, 64'hDEAD_BEEF_0000_FFFF, 64'h1234, 6'd5,
             mk("reset", 64'd0, 0, 0, 0, 0));
        step(1'b0, 3'b010, 64'd4, 64'd3, 6'd0, mk("post_rst_add", 64'd7, 0, 0, 0, 0));

        // Back-to-back sweep of all eight codes
        step(1'b0, 3'b000, 64'h4, 64'h3, 6'd8, mk("sw_and", 64'd0, 0, 1, 0, 0));
        step(1'b0, 3'b001, 64'h4, 64'h3, 6'd8, mk("sw_or", 64'd7, 0, 0, 0, 0));
        step(1'b0, 3'b010, 64'h4, 64'h3, 6'd8, mk("sw_add", 64'd7, 0, 0, 0, 0));
        step(1'b0, 3'b011, 64'h4, 64'h3, 6'd8, mk("sw_lsl", 64'h400, 0, 0, 0, 0));
        step(1'b0, 3'b100, 64'h4, 64'h3, 6'd8, mk("sw_lsr", 64'd0, 0, 1, 0, 0));
        step(1'b0, 3'b101, 64'h4, 64'h3, 6'd8, mk("sw_xor", 64'd7, 0, 0, 0, 0));
        step(1'b0, 3'b110, 64'h4, 64'h3, 6'd8, mk("sw_sub", 64'd1, 0, 0, 0, 1));
        step(1'b0, 3'b111, 64'h4, 64'h3, 6'd8, mk("sw_passb", 64'd3, 0, 0, 0, 0));

        // Overflow, carry and borrow corners
        step(1'b0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
             mk("add_ovf", 64'h8000_0000_0000_0000, 1, 0, 1, 0));
        step(1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
             mk("add_carry", 64'd0, 0, 1, 0, 1));
        step(1'b0, 3'b110, 64'd3, 64'd4, 6'd0,
             mk("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0));
        step(1'b0, 3'b110, 64'd5, 64'd5, 6'd0, mk("sub_equal", 64'd0, 0, 1, 0, 1));
        step(1'b0, 3'b110, 64'h8000_0000_0000_0000, 64'd1, 6'd0,
             mk("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1));

        // Shift extremes; B must be ignored
        step(1'b0, 3'b011, 64'd1, 64'hFFFF, 6'd63,
             mk("lsl_63", 64'h8000_0000_0000_0000, 1, 0, 0, 0));
        step(1'b0, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF, 6'd63,
             mk("lsr_63", 64'd1, 0, 0, 0, 0));
        step(1'b0, 3'b011, 64'hA5A5_0000_1234_5678, 64'd9, 6'd0,
             mk("lsl_0", 64'hA5A5_0000_1234_5678, 1, 0, 0, 0));
        step(1'b0, 3'b100, 64'h0123_4567_89AB_CDEF, 64'd9, 6'd0,
             mk("lsr_0", 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0));
        step(1'b0, 3'b100, 64'hF000_0000_0000_0000, 64'd0, 6'd4,
             mk("lsr_fill0", 64'h0F00_0000_0000_0000, 0, 0, 0, 0));

        // Reset mid-stream, then recovery
        step(1'b0, 3'b010, 64'd10, 64'd20, 6'd0, mk("ms_add", 64'd30, 0, 0, 0, 0));
        step(1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
             mk("ms_reset", 64'd0, 0, 0, 0, 0));
        step(1'b0, 3'b001, 64'hF0, 64'h0F, 6'd0, mk("ms_after", 64'hFF, 0, 0, 0, 0));

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra  = {$urandom, $urandom};
            rb  = (i % 4 == 0) ? ra : {$urandom, $urandom};
            rs  = 6'($urandom_range(0, 63));
            rop = 3'(i % 8);
            step(1'b0, rop, ra, rb, rs, model($sformatf("rnd%0d", i), rop, ra, rb, rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
